// File: rtl/inst_decode_queue_pkg.sv
// Shared decode definitions: control-bundle bit positions, MIPS opcode/funct
// encodings and the FIFO entry layout used by the decode queue.
package inst_decode_queue_pkg;

  localparam int CTRL_W = 20;

  localparam int C_REGWRITE  = 19;
  localparam int C_REGDST    = 18;
  localparam int C_ALUSRC    = 17;
  localparam int C_BRANCH    = 16;
  localparam int C_MEMWRITE  = 15;
  localparam int C_MEMTOREG  = 14;
  localparam int C_JUMP      = 13;
  localparam int C_JALR      = 12;
  localparam int C_SIGN_EXT  = 11;
  localparam int C_HILODST   = 10;
  localparam int C_HILOWRITE = 9;
  localparam int C_HILOREAD  = 8;
  localparam int C_MEMREAD   = 7;
  localparam int C_RAWRITE   = 6;
  localparam int C_BREAK     = 5;
  localparam int C_SYSCALL   = 4;
  localparam int C_CP0WE     = 3;
  localparam int C_CP0READ   = 2;
  localparam int C_ERET      = 1;
  localparam int C_INVALID   = 0;

  localparam logic [5:0] OP_RTYPE  = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                         OP_JAL    = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                         OP_BLEZ   = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08,
                         OP_ADDIU  = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI   = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E,
                         OP_LUI    = 6'h0F, OP_COP0   = 6'h10, OP_LB    = 6'h20,
                         OP_LH     = 6'h21, OP_LW     = 6'h23, OP_LBU   = 6'h24,
                         OP_LHU    = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29,
                         OP_SW     = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL   = 6'h02, F_SRA  = 6'h03, F_SLLV  = 6'h04,
                         F_SRLV = 6'h06, F_SRAV  = 6'h07, F_JR   = 6'h08, F_JALR  = 6'h09,
                         F_SYSC = 6'h0C, F_BREAK = 6'h0D, F_MFHI = 6'h10, F_MTHI  = 6'h11,
                         F_MFLO = 6'h12, F_MTLO  = 6'h13, F_MULT = 6'h18, F_MULTU = 6'h19,
                         F_DIV  = 6'h1A, F_DIVU  = 6'h1B, F_ADD  = 6'h20, F_ADDU  = 6'h21,
                         F_SUB  = 6'h22, F_SUBU  = 6'h23, F_AND  = 6'h24, F_OR    = 6'h25,
                         F_XOR  = 6'h26, F_NOR   = 6'h27, F_SLT  = 6'h2A, F_SLTU  = 6'h2B;

  localparam logic [4:0]  RS_MFC0 = 5'b00000, RS_MTC0 = 5'b00100;
  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        adel;
  } fifo_entry_t;

  // Any control transfer opens a delay slot for the following instruction.
  function automatic logic opens_delay_slot(input logic [CTRL_W-1:0] ctrl);
    return ctrl[C_BRANCH] | ctrl[C_JUMP];
  endfunction

endpackage

// File: rtl/inst_decode_queue_if.sv
// Fetch-side and decode-side handshake bundle of the decode queue.
interface inst_decode_queue_if;
  import inst_decode_queue_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [31:0]       in_pc;
  logic              in_adel;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [31:0]       out_pc;
  logic              out_adel;
  logic              out_in_delayslot;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_instr, in_pc, in_adel, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_adel, out_in_delayslot, out_ctrl
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_adel, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_adel, out_in_delayslot, out_ctrl
  );
endinterface

// File: rtl/inst_decode_queue_main_decode_comb.sv
// Combinational MIPS main decoder: instruction word to 20-bit control bundle.
module main_decode_comb
  import inst_decode_queue_pkg::*;
#(
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic [31:0]       instr_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [5:0] op, funct;
  logic [4:0] rs;
  logic       rt4, known;
  logic [CTRL_W-1:0] c;

  assign op    = instr_i[31:26];
  assign rs    = instr_i[25:21];
  assign rt4   = instr_i[20];
  assign funct = instr_i[5:0];

  always_comb begin
    c     = '0;
    known = 1'b1;
    case (op)
      OP_RTYPE: begin
        c[C_REGWRITE] = 1'b1;
        c[C_REGDST]   = 1'b1;
        case (funct)
          F_JR: begin
            c[C_REGWRITE] = 1'b0;
            c[C_REGDST]   = 1'b0;
            c[C_BRANCH]   = 1'b1;
            c[C_JUMP]     = 1'b1;
          end
          F_JALR: begin
            c[C_BRANCH] = 1'b1;
            c[C_JUMP]   = 1'b1;
            c[C_JALR]   = 1'b1;
          end
          F_SYSC, F_BREAK: begin
            c[C_REGWRITE] = 1'b0;
            c[C_REGDST]   = 1'b0;
            c[C_SYSCALL]  = (funct == F_SYSC);
            c[C_BREAK]    = (funct == F_BREAK);
          end
          F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            c[C_HILOWRITE] = 1'b1;
            c[C_HILODST]   = (funct == F_MTHI);
          end
          F_MFHI, F_MFLO: begin
            c[C_HILOREAD] = 1'b1;
            c[C_HILODST]  = (funct == F_MFHI);
          end
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU, F_SUB,
          F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: ;
          default: known = !STRICT_DECODE;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        c[C_REGWRITE] = 1'b1;
        c[C_ALUSRC]   = 1'b1;
      end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        c[C_REGWRITE] = 1'b1;
        c[C_ALUSRC]   = 1'b1;
        c[C_MEMTOREG] = 1'b1;
        c[C_MEMREAD]  = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        c[C_ALUSRC]   = 1'b1;
        c[C_MEMWRITE] = 1'b1;
      end
      OP_J:  c[C_JUMP] = 1'b1;
      OP_JAL: begin
        c[C_REGWRITE] = 1'b1;
        c[C_JUMP]     = 1'b1;
        c[C_JALR]     = 1'b1;
        c[C_RAWRITE]  = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ: c[C_BRANCH] = 1'b1;
      // rt[4] selects the linking forms BGEZAL/BLTZAL
      OP_REGIMM: begin
        c[C_BRANCH]   = 1'b1;
        c[C_REGWRITE] = rt4;
        c[C_JALR]     = rt4;
        c[C_RAWRITE]  = rt4;
      end
      OP_COP0: begin
        if (instr_i == ERET_WORD)
          c[C_ERET] = 1'b1;
        else if (rs == RS_MFC0 && instr_i[10:0] == 11'd0) begin
          c[C_REGWRITE] = 1'b1;
          c[C_CP0READ]  = 1'b1;
        end else if (rs == RS_MTC0 && instr_i[10:0] == 11'd0)
          c[C_CP0WE] = 1'b1;
        else
          known = !STRICT_DECODE;
      end
      default: known = 1'b0;
    endcase

    if (known) begin
      c[C_SIGN_EXT] = |(op[5:2] ^ 4'b0011);
      ctrl_o        = c;
    end else begin
      ctrl_o            = '0;
      ctrl_o[C_INVALID] = 1'b1;
    end
  end

endmodule

// File: rtl/inst_decode_queue.sv
// Buffered decode stage: fetch FIFO, registered decoded bundle with valid/ready
// handshake, branch delay-slot tracking and flush.
module inst_decode_queue
  import inst_decode_queue_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter bit STRICT_DECODE = 1'b1
) (
  input logic             clk,
  input logic             rst,
  input logic             flush,
  inst_decode_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);

  fifo_entry_t       mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]       count_q, count_d;
  logic              ov_q, ov_d, adel_q, adel_d, ids_q, ids_d, dsp_q, dsp_d;
  logic [31:0]       instr_q, instr_d, pc_q, pc_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d, head_ctrl;
  fifo_entry_t       head;
  logic              full, enq, load;

  assign full = (count_q == (PW+1)'(DEPTH));
  assign enq  = bus.in_valid && !full;
  assign load = (count_q != '0) && (!ov_q || bus.out_ready);
  assign head = mem_q[rptr_q];

  main_decode_comb #(.STRICT_DECODE(STRICT_DECODE)) u_dec (
    .instr_i (head.instr),
    .ctrl_o  (head_ctrl)
  );

  always_ff @(posedge clk) begin
    if (enq && !flush) mem_q[wptr_q] <= '{instr: bus.in_instr, pc: bus.in_pc, adel: bus.in_adel};
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ov_d    = ov_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    adel_d  = adel_q;
    ids_d   = ids_q;
    ctrl_d  = ctrl_q;
    dsp_d   = dsp_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ov_d    = 1'b0;
      instr_d = '0;
      pc_d    = '0;
      adel_d  = 1'b0;
      ids_d   = 1'b0;
      ctrl_d  = '0;
      dsp_d   = 1'b0;
    end else begin
      if (enq) wptr_d = wptr_q + 1'b1;
      if (load) begin
        rptr_d  = rptr_q + 1'b1;
        ov_d    = 1'b1;
        instr_d = head.instr;
        pc_d    = head.pc;
        adel_d  = head.adel;
        ctrl_d  = head_ctrl;
        // the pending flag belongs to this load; the new head may re-arm it
        ids_d   = dsp_q;
        dsp_d   = opens_delay_slot(head_ctrl);
      end else if (bus.out_ready) begin
        ov_d = 1'b0;
      end
      count_d = count_q + {{PW{1'b0}}, enq} - {{PW{1'b0}}, load};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ov_q    <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      adel_q  <= 1'b0;
      ids_q   <= 1'b0;
      ctrl_q  <= '0;
      dsp_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ov_q    <= ov_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      adel_q  <= adel_d;
      ids_q   <= ids_d;
      ctrl_q  <= ctrl_d;
      dsp_q   <= dsp_d;
    end
  end

  assign bus.in_ready         = !full;
  assign bus.out_valid        = ov_q;
  assign bus.out_instr        = instr_q;
  assign bus.out_pc           = pc_q;
  assign bus.out_adel         = adel_q;
  assign bus.out_in_delayslot = ids_q;
  assign bus.out_ctrl         = ctrl_q;

endmodule
